// File: rtl/bus_codes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : bus_codes_pkg                                                  |
// | Brief     : Shared bus source/destination code map and datapath widths.    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package bus_codes_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CODE_R0      = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R1      = 5'd1;
    localparam logic [CODE_W-1:0] CODE_R2      = 5'd2;
    localparam logic [CODE_W-1:0] CODE_R3      = 5'd3;
    localparam logic [CODE_W-1:0] CODE_R4      = 5'd4;
    localparam logic [CODE_W-1:0] CODE_R5      = 5'd5;
    localparam logic [CODE_W-1:0] CODE_R6      = 5'd6;
    localparam logic [CODE_W-1:0] CODE_R7      = 5'd7;
    localparam logic [CODE_W-1:0] CODE_R8      = 5'd8;
    localparam logic [CODE_W-1:0] CODE_R9      = 5'd9;
    localparam logic [CODE_W-1:0] CODE_R10     = 5'd10;
    localparam logic [CODE_W-1:0] CODE_R11     = 5'd11;
    localparam logic [CODE_W-1:0] CODE_R12     = 5'd12;
    localparam logic [CODE_W-1:0] CODE_R13     = 5'd13;
    localparam logic [CODE_W-1:0] CODE_R14     = 5'd14;
    localparam logic [CODE_W-1:0] CODE_R15     = 5'd15;
    localparam logic [CODE_W-1:0] CODE_HI      = 5'd16;
    localparam logic [CODE_W-1:0] CODE_LO      = 5'd17;
    localparam logic [CODE_W-1:0] CODE_ZHI     = 5'd18;
    localparam logic [CODE_W-1:0] CODE_ZLO     = 5'd19;
    localparam logic [CODE_W-1:0] CODE_PC      = 5'd20;
    localparam logic [CODE_W-1:0] CODE_MDR     = 5'd21;
    localparam logic [CODE_W-1:0] CODE_INPORT  = 5'd22;
    localparam logic [CODE_W-1:0] CODE_SIGNEXT = 5'd23;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Only the register file, hi/lo, pc and mdr accept bus writes.
    function automatic logic is_writable(input logic [CODE_W-1:0] code);
        return (code <= CODE_LO) || (code == CODE_PC) || (code == CODE_MDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dest_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : bus_dest_bank_if                                               |
// | Brief     : Write handshake plus pc/mdr side controls for the dest bank.   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface bus_dest_bank_if;
    import bus_codes_pkg::*;

    logic [DATA_W-1:0] busIn;
    logic [CODE_W-1:0] dest;
    logic              destValid;
    logic              destReady;
    logic              hold;
    logic              incPC;
    logic              mdrRead;
    logic [DATA_W-1:0] mdrMemIn;

    modport master (
        output busIn, dest, destValid, hold, incPC, mdrRead, mdrMemIn,
        input  destReady
    );

    modport slave (
        input  busIn, dest, destValid, hold, incPC, mdrRead, mdrMemIn,
        output destReady
    );
endinterface
`default_nettype wire

// File: rtl/bus_dest_bank_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bus_dest_decode                                                |
// | Brief     : Destination code to one-hot load enables plus illegal flag.    |
// |             R0_ZERO_EN: code 0 decodes to no enable and is not illegal.    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module bus_dest_decode
    import bus_codes_pkg::*;
(
    input  wire logic [CODE_W-1:0] code,
    output logic      [31:0]       load_en,
    output logic                   illegal
);

    always_comb begin
        load_en = '0;
        illegal = 1'b0;
        if (is_writable(code)) begin
            load_en[code] = 1'b1;
        end else begin
            illegal = 1'b1;
        end
`ifdef R0_ZERO_EN
        if (code == CODE_R0) begin
            load_en = '0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/bus_dest_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bus_dest_bank                                                  |
// | Brief     : One-deep buffered bus write port into r0-r15, hi, lo, pc, mdr. |
// |             R0_ZERO_EN: r0 is hardwired to zero.                           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module bus_dest_bank
    import bus_codes_pkg::*;
(
    input  wire logic        clock,
    input  wire logic        clear,
    bus_dest_bank_if.slave   busif,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] r8,
    output logic [DATA_W-1:0] r9,
    output logic [DATA_W-1:0] r10,
    output logic [DATA_W-1:0] r11,
    output logic [DATA_W-1:0] r12,
    output logic [DATA_W-1:0] r13,
    output logic [DATA_W-1:0] r14,
    output logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] mdr,
    output logic              errFlag,
    output logic              wrConflict
);

    buf_state_t        r_state;
    logic [DATA_W-1:0] r_buf_data;
    logic [CODE_W-1:0] r_buf_dest;

    logic [DATA_W-1:0] r_gpr [16];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_mdr;
    logic              r_err;
    logic              r_conflict;

    logic              w_accept;
    logic              w_commit;
    logic [31:0]       w_load_en;
    logic              w_illegal;
    logic              w_unused_en;

    assign busif.destReady = !clear && ((r_state == BUF_EMPTY) || !busif.hold);
    assign w_accept        = busif.destValid && busif.destReady;
    assign w_commit        = (r_state == BUF_FULL) && !busif.hold;

    // Read-only and out-of-range codes never produce an enable.
    assign w_unused_en = ^{w_load_en[31:22], w_load_en[19:18]};

    bus_dest_decode u_decode (
        .code    (r_buf_dest),
        .load_en (w_load_en),
        .illegal (w_illegal)
    );

    // Buffer FSM: a commit and a fresh accept may share one edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= BUF_EMPTY;
            r_buf_data <= '0;
            r_buf_dest <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_accept) begin
                        r_state    <= BUF_FULL;
                        r_buf_data <= busif.busIn;
                        r_buf_dest <= busif.dest;
                    end
                end
                BUF_FULL: begin
                    if (w_accept) begin
                        r_buf_data <= busif.busIn;
                        r_buf_dest <= busif.dest;
                    end else if (w_commit) begin
                        r_state <= BUF_EMPTY;
                    end
                end
                default: r_state <= BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi       <= '0;
            r_lo       <= '0;
            r_pc       <= '0;
            r_mdr      <= '0;
            r_err      <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_commit && w_load_en[i]) begin
                    r_gpr[i] <= r_buf_data;
                end
            end
            if (w_commit && w_load_en[CODE_HI]) begin
                r_hi <= r_buf_data;
            end
            if (w_commit && w_load_en[CODE_LO]) begin
                r_lo <= r_buf_data;
            end
            // A bus write to pc overrides the increment.
            if (w_commit && w_load_en[CODE_PC]) begin
                r_pc <= r_buf_data;
            end else if (busif.incPC) begin
                r_pc <= r_pc + 32'd1;
            end
            // Memory load owns mdr; a colliding bus write is dropped and flagged.
            if (busif.mdrRead) begin
                r_mdr <= busif.mdrMemIn;
            end else if (w_commit && w_load_en[CODE_MDR]) begin
                r_mdr <= r_buf_data;
            end
            r_conflict <= w_commit && w_load_en[CODE_MDR] && busif.mdrRead;
            if (w_commit && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef R0_ZERO_EN
    assign r0 = '0;
`else
    assign r0 = r_gpr[0];
`endif
    assign r1         = r_gpr[1];
    assign r2         = r_gpr[2];
    assign r3         = r_gpr[3];
    assign r4         = r_gpr[4];
    assign r5         = r_gpr[5];
    assign r6         = r_gpr[6];
    assign r7         = r_gpr[7];
    assign r8         = r_gpr[8];
    assign r9         = r_gpr[9];
    assign r10        = r_gpr[10];
    assign r11        = r_gpr[11];
    assign r12        = r_gpr[12];
    assign r13        = r_gpr[13];
    assign r14        = r_gpr[14];
    assign r15        = r_gpr[15];
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign pc         = r_pc;
    assign mdr        = r_mdr;
    assign errFlag    = r_err;
    assign wrConflict = r_conflict;

endmodule
`default_nettype wire

// File: doc/bus_dest_bank.md
# bus_dest_bank

Destination side of the datapath bus. Accepts a 32-bit bus word tagged with a 5-bit destination code, buffers it one entry deep, and commits it into the owning register on the next edge. It holds r0–r15, hi, lo, pc and mdr, and feeds them back to the bus source multiplexer using the same code map. Memory-side mdr loads and PC increment are also handled here.

## Interface
- No parameters; widths are fixed at 32-bit data and 5-bit codes.
- `clock` in 1: the single clock, rising edge.
- `clear` in 1: synchronous, active-high reset.
- `busIn` in 32: bus word to be written.
- `dest` in 5: destination code, same map as the bus source select.
- `destValid` in 1: write request.
- `destReady` out 1: buffer can accept.
- `hold` in 1: stalls the commit stage.
- `incPC` in 1: pc increment request.
- `mdrRead` in 1: load mdr from memory.
- `mdrMemIn` in 32: memory read data.
- `r0`..`r15` out 32 each: general registers.
- `hi`, `lo`, `pc`, `mdr` out 32 each: special registers.
- `errFlag` out 1: sticky illegal-destination flag.
- `wrConflict` out 1: one-cycle pulse when a commit is lost to `mdrRead`.

## Operation
- Code map:
  - 0–15: r0–r15.
  - 16: hi.
  - 17: lo.
  - 20: pc.
  - 21: mdr.
  - 18, 19, 22, 23 (zhi, zlo, inport, signExt) are read-only. These and 24–31 are illegal.
- Buffer state machine: EMPTY → FULL on accept. FULL → EMPTY on commit with no new accept. FULL → FULL on commit with a simultaneous accept.
- Accept: `destValid && destReady` at an edge latches `busIn` and `dest` into the buffer.
- `destReady = (state==EMPTY) || !hold`. It is combinational and held low while `clear` is high.
- Commit: at an edge with state FULL and `!hold`, the buffered word is written to the decoded register.
  - Illegal code: the word is dropped and `errFlag` is set. `errFlag` stays set until `clear`.
- `incPC`: pc ← pc+1 modulo 2^32; 0xFFFFFFFF wraps to 0.
  - A commit to pc in the same cycle wins and the increment is dropped.
- `mdrRead`: mdr ← `mdrMemIn`.
  - A commit to mdr in the same cycle loses: mdr takes `mdrMemIn`, the buffered word is discarded, and `wrConflict` pulses for one cycle.
- Back-to-back writes to the same register commit in order; the last one wins.

## Timing
- Reset: a `clear` edge sets all registers to 0, `errFlag` 0, `wrConflict` 0 and buffer EMPTY. Any in-flight buffered word is discarded. `destValid` is ignored during `clear`.
- Latency: accept at edge N gives commit at edge N+1 (if `hold` is low). The value is visible on outputs after edge N+1.
- Throughput is one write per cycle while `hold` is low.
- With `hold` high and buffer FULL: `destReady` is 0 and the buffer keeps its contents unchanged.
- `incPC` and `mdrRead` take effect at the same edge they are sampled (one-cycle latency) and ignore `hold`.
- Outputs are registered, with no combinational path from `busIn` to any register output.
- `wrConflict` is high exactly one cycle, for the cycle after the conflicting edge.

## Configuration
- `R0_ZERO_EN` defined:
  - r0 always reads 0.
  - Commits to code 0 are accepted and discarded silently (no `errFlag`).
- `R0_ZERO_EN` undefined: r0 is an ordinary writable register.

## Structure
- Shared package `bus_codes_pkg` holds:
  - the 5-bit destination/source code constants (`CODE_R0`..`CODE_R15`, `CODE_HI`, `CODE_LO`, `CODE_ZHI`, `CODE_ZLO`, `CODE_PC`, `CODE_MDR`, `CODE_INPORT`, `CODE_SIGNEXT`);
  - the data width constant.
- The bus source multiplexer imports the same package.
- One sub-module, `bus_dest_decode`: combinational, code → one-hot 32 load enables plus an `illegal` flag.

## Test plan
- Write 0xDEADBEEF to code 5 with `hold` 0 → `destReady` is 1 and r5 = 0xDEADBEEF after the second edge. All other registers stay 0.
- Three back-to-back writes to r3 (1, 2, 3) with `hold` 0 → r3 shows 1, 2, 3 on consecutive cycles and `destReady` stays 1.
- Accept a write to hi, then hold `hold` high for 4 cycles → `destReady` is 0 and hi stays 0. Release `hold` → hi updates on the next edge.
- pc = 0xFFFFFFFF with `incPC` → pc = 0. A commit of 0x100 to pc together with `incPC` → pc = 0x100.
- Commit 0x11 to mdr together with `mdrRead` and `mdrMemIn` = 0x22 → mdr = 0x22 and `wrConflict` pulses for one cycle.
- Write to code 19, then code 0 →
  - `errFlag` = 1, sticky until `clear`.
  - With `R0_ZERO_EN`: r0 stays 0.
  - Without it: r0 takes the value.
  - `clear` while the buffer is FULL → the buffered write never commits.
